// File: rtl/rotary_input_decoder_pkg.sv
// Shared types and constants for the rotary encoder decoder.
package rotary_input_decoder_pkg;

    typedef enum logic [2:0] {
        StRest,
        StCw1,
        StCw2,
        StCw3,
        StCcw1,
        StCcw2,
        StCcw3,
        StResync
    } quad_state_e;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Debounced {a,b} pairs along the quadrature cycle
    localparam logic [1:0] PAIR_11 = 2'b11;
    localparam logic [1:0] PAIR_01 = 2'b01;
    localparam logic [1:0] PAIR_00 = 2'b00;
    localparam logic [1:0] PAIR_10 = 2'b10;

endpackage

// File: rtl/input_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw input.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic [CntW-1:0] r_cnt;
    logic            r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= {2{RESET_VAL}};
            r_cnt   <= '0;
            r_level <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            // Any sample matching the accepted level restarts the stability count
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CntMax) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/rotary_input_decoder.sv
// Rotary encoder front end: debounced quadrature decode into step/dir/pos plus
// a debounced push button with a press pulse.
module rotary_input_decoder
    import rotary_input_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned POS_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rot_a,
    input  logic                 rot_b,
    input  logic                 rot_center,
    output logic                 step,
    output logic                 dir,
    output logic                 press,
    output logic                 btn_level,
    output logic [POS_WIDTH-1:0] pos
);

    localparam logic [POS_WIDTH-1:0] PosOne = 1;

    logic        w_deb_a;
    logic        w_deb_b;
    logic        w_deb_c;
    logic [1:0]  w_pair;

    quad_state_e r_state;
    quad_state_e w_state_d;
    logic        w_step_d;
    logic        w_dir_d;

    logic                 r_step;
    logic                 r_dir;
    logic [POS_WIDTH-1:0] r_pos;
    logic                 r_btn_prev;
    logic                 r_press;

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_deb_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (rot_a),
        .o_level (w_deb_a)
    );

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1)
    ) u_deb_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (rot_b),
        .o_level (w_deb_b)
    );

    input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b0)
    ) u_deb_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (rot_center),
        .o_level (w_deb_c)
    );

    assign w_pair = {w_deb_a, w_deb_b};

    // Each state stays put on its own pair; unlisted pairs are two-bit jumps -> resync
    always_comb begin
        w_state_d = r_state;
        w_step_d  = 1'b0;
        w_dir_d   = r_dir;
        unique case (r_state)
            StRest: begin
                case (w_pair)
                    PAIR_01: w_state_d = StCw1;
                    PAIR_10: w_state_d = StCcw1;
                    PAIR_00: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCw1: begin
                case (w_pair)
                    PAIR_00: w_state_d = StCw2;
                    PAIR_11: w_state_d = StRest;
                    PAIR_10: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCw2: begin
                case (w_pair)
                    PAIR_10: w_state_d = StCw3;
                    PAIR_01: w_state_d = StCw1;
                    PAIR_11: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCw3: begin
                case (w_pair)
                    PAIR_11: begin
                        w_state_d = StRest;
                        w_step_d  = 1'b1;
                        w_dir_d   = DIR_CW;
                    end
                    PAIR_00: w_state_d = StCw2;
                    PAIR_01: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCcw1: begin
                case (w_pair)
                    PAIR_00: w_state_d = StCcw2;
                    PAIR_11: w_state_d = StRest;
                    PAIR_01: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCcw2: begin
                case (w_pair)
                    PAIR_01: w_state_d = StCcw3;
                    PAIR_10: w_state_d = StCcw1;
                    PAIR_11: w_state_d = StResync;
                    default: ;
                endcase
            end
            StCcw3: begin
                case (w_pair)
                    PAIR_11: begin
                        w_state_d = StRest;
                        w_step_d  = 1'b1;
                        w_dir_d   = DIR_CCW;
                    end
                    PAIR_00: w_state_d = StCcw2;
                    PAIR_10: w_state_d = StResync;
                    default: ;
                endcase
            end
            StResync: begin
                if (w_pair == PAIR_11) begin
                    w_state_d = StRest;
                end
            end
            default: w_state_d = StResync;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRest;
            r_step  <= 1'b0;
            r_dir   <= 1'b0;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_d;
            r_step  <= w_step_d;
            if (w_step_d) begin
                r_dir <= w_dir_d;
                r_pos <= (w_dir_d == DIR_CW) ? r_pos + PosOne : r_pos - PosOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_btn_prev <= w_deb_c;
            r_press    <= w_deb_c & ~r_btn_prev;
        end
    end

    assign step      = r_step;
    assign dir       = r_dir;
    assign pos       = r_pos;
    assign press     = r_press;
    assign btn_level = w_deb_c;

endmodule

// File: tb/tb_rotary_input_decoder.sv
// Bench for rotary_input_decoder: vector table, debounce corner cases, and a
// randomized walk checked against a quarter-step counting model.
module tb_rotary_input_decoder;

    localparam int unsigned DEB = 4;
    localparam int unsigned PW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rot_a = 1'b1;
    logic          rot_b = 1'b1;
    logic          rot_center = 1'b0;
    logic          step;
    logic          dir;
    logic          press;
    logic          btn_level;
    logic [PW-1:0] pos;

    int n_tests = 0;
    int n_fail = 0;
    int step_seen = 0;
    int press_seen = 0;

    rotary_input_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .POS_WIDTH       (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rot_a      (rot_a),
        .rot_b      (rot_b),
        .rot_center (rot_center),
        .step       (step),
        .dir        (dir),
        .press      (press),
        .btn_level  (btn_level),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step === 1'b1) step_seen++;
        if (press === 1'b1) press_seen++;
    end

    typedef struct {
        logic a;
        logic b;
        logic c;
        int   hold;
        int   d_step;
        int   d_press;
        int   pos;
        logic dir;
        logic btn;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input int n);
        rot_a = a;
        rot_b = b;
        rot_center = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cw_detent();
        drive(1'b0, 1'b1, rot_center, 10);
        drive(1'b0, 1'b0, rot_center, 10);
        drive(1'b1, 1'b0, rot_center, 10);
        drive(1'b1, 1'b1, rot_center, 10);
    endtask

    initial begin
        int s0, p0, pos0, low_seen;
        int ph, qn, mpos, exp_steps, exp_press;
        logic mdir, resync, c_cur, c_new;

        // Reset state
        #2;
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_press", press, 0);
        chk("rst_btn", btn_level, 0);
        chk("rst_pos", pos, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // {a,b,c,hold, step delta, press delta, pos, dir, btn}
        tbl.push_back('{1, 1, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 10, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 0, 0, 10, 0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 1, 1, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 1, 1, 0});
        tbl.push_back('{1, 1, 0, 10, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 10, 1, 0, 15, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 1, 1, 50, 0, 1, 15, 0, 1});
        tbl.push_back('{1, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 0, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{0, 1, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{0, 0, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 0, 0, 10, 0, 0, 15, 0, 0});
        tbl.push_back('{1, 1, 1, 10, 1, 1, 0, 1, 1});
        tbl.push_back('{1, 1, 0, 10, 0, 0, 0, 1, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            s0 = step_seen;
            p0 = press_seen;
            drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].hold);
            chk($sformatf("vec%0d_step", i), step_seen - s0, tbl[i].d_step);
            chk($sformatf("vec%0d_press", i), press_seen - p0, tbl[i].d_press);
            chk($sformatf("vec%0d_pos", i), pos, tbl[i].pos);
            chk($sformatf("vec%0d_dir", i), dir, tbl[i].dir);
            chk($sformatf("vec%0d_btn", i), btn_level, tbl[i].btn);
        end

        // Short glitch on a: never accepted
        s0 = step_seen;
        low_seen = 0;
        rot_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 rot_a = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (dut.w_deb_a == 1'b0) low_seen = 1;
        end
        chk("glitch3_deb_a", low_seen, 0);

        // Glitch of exactly DEB cycles: debounced a falls on edge 2+DEB
        rot_a = 1'b0;
        repeat (4) @(posedge clk);
        #1 rot_a = 1'b1;
        @(posedge clk);
        #1 chk("glitch4_deb_a_edge5", dut.w_deb_a, 1);
        @(posedge clk);
        #1 chk("glitch4_deb_a_edge6", dut.w_deb_a, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("glitch4_deb_a_back", dut.w_deb_a, 1);
        chk("glitch_step", step_seen - s0, 0);

        // Button bounce every 2 cycles
        p0 = press_seen;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 2);
        end
        drive(1'b1, 1'b1, 1'b0, 10);
        chk("bounce_press", press_seen - p0, 0);
        chk("bounce_btn", btn_level, 0);

        // 16 CW detents wrap the position
        s0 = step_seen;
        pos0 = int'(pos);
        cw_detent();
        chk("wrap_first_pos", pos, (pos0 + 1) % 16);
        for (int i = 1; i < 16; i++) cw_detent();
        chk("wrap_steps", step_seen - s0, 16);
        chk("wrap_pos", pos, pos0);
        chk("wrap_dir", dir, 1);

        // Randomized walk against the quarter-step model
        ph = 0;
        qn = 0;
        resync = 1'b0;
        mpos = int'(pos);
        mdir = dir;
        c_cur = rot_center;
        exp_steps = 0;
        exp_press = 0;
        s0 = step_seen;
        p0 = press_seen;
        for (int i = 0; i < 200; i++) begin
            int r, d;
            r = $urandom_range(0, 9);
            d = (r < 4) ? 1 : ((r < 8) ? -1 : 0);
            if (r == 8) begin
                ph = (ph + 2) % 4;
                qn = 0;
                resync = (ph != 0);
            end else if (d != 0) begin
                ph = (ph + d + 4) % 4;
                if (resync) begin
                    if (ph == 0) resync = 1'b0;
                end else begin
                    qn = qn + d;
                    if (ph == 0) begin
                        if (qn == 4) begin
                            exp_steps++;
                            mpos = (mpos + 1) % 16;
                            mdir = 1'b1;
                        end else if (qn == -4) begin
                            exp_steps++;
                            mpos = (mpos + 15) % 16;
                            mdir = 1'b0;
                        end
                        qn = 0;
                    end
                end
            end
            c_new = ($urandom_range(0, 3) == 0) ? ~c_cur : c_cur;
            if (c_new && !c_cur) exp_press++;
            c_cur = c_new;
            drive((ph == 0 || ph == 3), (ph == 0 || ph == 1), c_cur, $urandom_range(10, 14));
            chk($sformatf("rnd%0d_steps", i), step_seen - s0, exp_steps);
            chk($sformatf("rnd%0d_press", i), press_seen - p0, exp_press);
            chk($sformatf("rnd%0d_pos", i), pos, mpos);
            chk($sformatf("rnd%0d_dir", i), dir, mdir);
            chk($sformatf("rnd%0d_btn", i), btn_level, c_cur);
        end

        // Return to rest, then reset while in CW2 with the button held
        drive((ph == 0 || ph == 3), (ph == 0 || ph == 1), 1'b1, 10);
        if (ph != 0) drive(1'b1, 1'b1, 1'b1, 10);
        cw_detent();
        drive(1'b0, 1'b1, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b1, 10);
        chk("pre_rst_btn", btn_level, 1);
        rst_n = 1'b0;
        #2;
        chk("midrst_step", step, 0);
        chk("midrst_dir", dir, 0);
        chk("midrst_press", press, 0);
        chk("midrst_btn", btn_level, 0);
        chk("midrst_pos", pos, 0);
        rot_a = 1'b1;
        rot_b = 1'b0;
        rot_center = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        s0 = step_seen;
        p0 = press_seen;
        drive(1'b1, 1'b0, 1'b0, 10);
        drive(1'b1, 1'b1, 1'b0, 10);
        chk("postrst_step", step_seen - s0, 0);
        chk("postrst_press", press_seen - p0, 0);
        chk("postrst_pos", pos, 0);
        cw_detent();
        chk("postrst_detent_step", step_seen - s0, 1);
        chk("postrst_detent_pos", pos, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
